// File: rtl/fib_seq_pkg.sv
// Shared constants for the additive-recurrence sequence generator.
package fib_seq_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Seed select values on the mode input; 3 aliases Fibonacci
  localparam logic [1:0] MODE_FIB    = 2'd0;
  localparam logic [1:0] MODE_LUCAS  = 2'd1;
  localparam logic [1:0] MODE_CUSTOM = 2'd2;

  // Built-in seed pairs (first term, second term)
  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;
  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_seq_core.sv
// Register pair (a, b) of the recurrence plus the carry flag of b.
// a is the term currently presented, b the next one; b_ovf marks that b
// came from a sum that carried out of WIDTH bits.
module fib_seq_core
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] seed_a_i,
  input  logic [WIDTH-1:0] seed_b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             b_ovf_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             b_ovf_q, b_ovf_d;
  logic [WIDTH:0]   sum;

  // Sum at WIDTH+1 bits so the top bit is the carry out
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Next-state selection: load seeds (never overflowed) or advance one step
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    b_ovf_d = b_ovf_q;
    if (load_i) begin
      a_d     = seed_a_i;
      b_d     = seed_b_i;
      b_ovf_d = 1'b0;
    end else if (step_i) begin
      a_d     = b_q;
      b_d     = sum[WIDTH-1:0];
      b_ovf_d = sum[WIDTH];
    end
  end

  // Register update with async clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      b_ovf_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      b_ovf_q <= b_ovf_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign b_ovf_o = b_ovf_q;

endmodule

// File: rtl/fib_seq_gen.sv
// Bounded additive-recurrence generator (Fibonacci / Lucas / custom seeds)
// on a valid/ready stream with term index and overflow detection.
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] num_terms,
  input  logic             ovf_wrap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic             load, step;
  logic [WIDTH-1:0] seed_a, seed_b;
  logic [WIDTH-1:0] a, b;
  logic             b_ovf;
  logic             last;

  // Seed pair chosen by mode at start time
  always_comb begin
    seed_a = WIDTH'(FIB_SEED0);
    seed_b = WIDTH'(FIB_SEED1);
    case (mode)
      MODE_LUCAS: begin
        seed_a = WIDTH'(LUCAS_SEED0);
        seed_b = WIDTH'(LUCAS_SEED1);
      end
      MODE_CUSTOM: begin
        seed_a = seed0;
        seed_b = seed1;
      end
      default: ;
    endcase
  end

  fib_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .seed_a_i (seed_a),
    .seed_b_i (seed_b),
    .a_o      (a),
    .b_o      (b),
    .b_ovf_o  (b_ovf)
  );

  // num_q is at least 1 whenever RUN is active, so the subtraction is safe
  assign last = (idx_q == (num_q - IDX_W'(1)));

  // FSM, index counter and handshake decisions
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    wrap_d  = wrap_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (num_terms != '0) begin
            load    = 1'b1;
            idx_d   = '0;
            num_d   = num_terms;
            wrap_d  = ovf_wrap;
            state_d = ST_RUN;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          if (last) begin
            state_d = ST_FIN;
          end else if (b_ovf && !wrap_q) begin
            // Next term wrapped: stop before it is ever presented
            state_d = ST_FIN;
            ovf_d   = 1'b1;
          end else begin
            // In wrap mode the flag rises as the wrapped term is presented
            step  = 1'b1;
            idx_d = idx_q + IDX_W'(1);
            ovf_d = ovf_q | b_ovf;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers with async clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // a only moves on a handshake, so data/index hold through stalls
  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_FIN);
  assign out_data  = a;
  assign out_index = idx_q;
  assign overflow  = ovf_q;

  // b is only needed through the core's sum; keep it visible for debug
  logic unused_b;
  assign unused_b = ^b;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen at WIDTH=8: stimulus pushes the
// expected terms, a negedge monitor compares what the DUT presents.
module tb_fib_seq_gen;

  localparam int W  = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  seed0, seed1;
  logic [IW-1:0] num_terms;
  logic          ovf_wrap;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          busy, done, overflow;

  fib_seq_gen #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .seed0(seed0), .seed1(seed1), .num_terms(num_terms),
    .ovf_wrap(ovf_wrap), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int i; } term_t;
  term_t sb[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int exp_done_cyc = -1;
  bit exp_ovf = 1'b0;
  bit done_seen = 1'b0;
  bit mon_en = 1'b0;
  int rdy_mode = 0;
  int rdy_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Ready pattern: 0 always high, 1 random, 2 repeating 1,0,0
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin out_ready = (rdy_cnt % 3 == 0); rdy_cnt++; end
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: compare every presented term against the scoreboard head
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("data", out_data, sb[0].d);
          chk("index", out_index, sb[0].i);
          if (out_ready) begin
            void'(sb.pop_front());
            if (sb.size() == 0) exp_done_cyc = cyc + 1;
          end
        end
      end
      if (done) begin
        chk("done_cycle", cyc, exp_done_cyc);
        chk("overflow_at_done", overflow, exp_ovf);
        done_seen = 1'b1;
        exp_done_cyc = -1;
      end else if (cyc == exp_done_cyc) begin
        chk("done_missing", 0, 1);
        exp_done_cyc = -1;
      end
    end
  end

  // Reference model: expand the recurrence with plain integers, then
  // decide which terms are emitted and the final overflow status.
  task automatic model(input int md, input int s0, input int s1, input int n,
                       input bit wrap);
    int t[$];
    bit of[$];
    bit ov;
    term_t e;
    case (md)
      1: begin t.push_back(2); t.push_back(1); end
      2: begin t.push_back(s0); t.push_back(s1); end
      default: begin t.push_back(0); t.push_back(1); end
    endcase
    of.push_back(0); of.push_back(0);
    for (int k = 2; k < n; k++) begin
      int s;
      s = t[k-2] + t[k-1];
      t.push_back(s % 256);
      of.push_back(s > 255);
    end
    ov = 0;
    for (int k = 0; k < n; k++) begin
      if (of[k] && !wrap) begin ov = 1; break; end
      e.d = t[k]; e.i = k;
      sb.push_back(e);
      ov = ov | of[k];
    end
    exp_ovf = ov;
  endtask

  // Launch one run and wait (bounded) for its done pulse
  task automatic run(input int md, input int s0, input int s1, input int n,
                     input bit wrap, input int rm, input bit glitch);
    @(posedge clk); #1;
    rdy_mode = rm; rdy_cnt = 0;
    mode = 2'(md); seed0 = W'(s0); seed1 = W'(s1);
    num_terms = IW'(n); ovf_wrap = wrap;
    start = 1'b1;
    done_seen = 1'b0;
    model(md, s0, s1, n, wrap);
    if (n == 0) exp_done_cyc = cyc + 2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_valid", out_valid, n != 0);
    chk("first_busy", busy, n != 0);
    begin
      int k;
      for (k = 0; k < 2000; k++) begin
        @(negedge clk); #1;
        if (done_seen) break;
        if (glitch) begin
          start = 1'($urandom_range(0, 1));
          num_terms = IW'($urandom);
          ovf_wrap = 1'($urandom);
          mode = 2'($urandom);
        end
      end
      start = 1'b0;
      if (k == 2000) chk("done_timeout", 0, 1);
    end
    chk("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
    chk("idle_no_valid", out_valid, 0);
    chk("overflow_sticky", overflow, exp_ovf);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; seed0 = '0; seed1 = '0;
    num_terms = '0; ovf_wrap = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    run(0, 0, 0, 10, 0, 0, 0);   // Fibonacci 0..34
    run(0, 0, 0, 20, 0, 0, 0);   // stops after 233, overflow
    run(0, 0, 0, 20, 1, 0, 0);   // wraps, 121 at index 14
    run(1, 0, 0, 6, 0, 2, 1);    // Lucas with stalls and start glitches
    run(2, 5, 5, 4, 0, 1, 0);    // custom seeds
    run(0, 0, 0, 0, 0, 0, 0);    // empty run
    run(2, 200, 100, 3, 0, 0, 0); // overflow on the very last term

    // Reset mid-run at index 3
    @(posedge clk); #1;
    rdy_mode = 0;
    mode = 2'd0; num_terms = 8'd10; ovf_wrap = 1'b0; start = 1'b1;
    model(0, 0, 0, 10, 0);
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (out_valid && out_index == 3) break;
      end
      if (k == 100) chk("reach_index3_timeout", 0, 1);
    end
    #2;
    mon_en = 1'b0; sb.delete(); exp_done_cyc = -1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_index", out_index, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    run(0, 0, 0, 5, 0, 0, 0);

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      run($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 40), 1'($urandom), $urandom_range(0, 2),
          1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
